// File: rtl/mul_share_sched_if.sv
// ============================================================================
// Module      : mul_share_sched_if
// Description : Request/response channel bundle for the shared-multiplier
//               scheduler. Adds req_acc when MULSCHED_ACC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul_share_sched_if #(
    parameter int NREQ = 4,
    parameter int WA   = 6,
    parameter int WB   = 5,
    parameter int WR   = 16
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*WA-1:0] req_a;
    logic [NREQ*WB-1:0] req_b;
`ifdef MULSCHED_ACC_EN
    logic [NREQ-1:0]    req_acc;
`endif
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [WR-1:0]      rsp_data;

    modport master (
`ifdef MULSCHED_ACC_EN
        output req_acc,
`endif
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
`ifdef MULSCHED_ACC_EN
        input  req_acc,
`endif
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

`default_nettype wire

// File: rtl/mul_share_sched.sv
// ============================================================================
// Module      : mul_share_sched
// Description : Round-robin scheduler sharing one multiplier datapath among
//               NREQ requesters; optional accumulate mode via MULSCHED_ACC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_share_sched #(
    parameter int NREQ   = 4,
    parameter int WA     = 6,
    parameter int WB     = 5,
    parameter int WR     = 16,
    parameter int DP_LAT = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mul_share_sched_if.slave   bus,
    output logic [WA-1:0]      dp_a,
    output logic [WB-1:0]      dp_b,
    input  wire logic [WR-1:0] dp_res,
    output logic               busy
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gid;
    logic [IDW-1:0] gsel;
    logic [1:0]     cnt;
    logic           found;
    logic           accept;
    logic           capture;
    logic           release_op;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [WR-1:0]  rsp_data_q;
    logic [WR-1:0]  result;

    // Rotating priority search starting at ptr
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req_valid[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                gsel  = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        capture    = 1'b0;
        release_op = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 2'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    release_op = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[gsel] = 1'b1;
    end

`ifdef MULSCHED_ACC_EN
    logic [WR-1:0] acc [NREQ];
    logic          acc_sel;

    assign result = acc_sel ? (acc[gid] + dp_res) : dp_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sel <= 1'b0;
            for (int i = 0; i < NREQ; i++) acc[i] <= '0;
        end else begin
            if (accept)  acc_sel  <= bus.req_acc[gsel];
            if (capture) acc[gid] <= result;
        end
    end
`else
    assign result = dp_res;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            gid         <= '0;
            cnt         <= '0;
            dp_a        <= '0;
            dp_b        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                dp_a <= bus.req_a[int'(gsel)*WA +: WA];
                dp_b <= bus.req_b[int'(gsel)*WB +: WB];
                gid  <= gsel;
                cnt  <= 2'(DP_LAT);
            end
            if (state == WAIT && cnt != 2'd0) cnt <= cnt - 2'd1;
            if (capture) begin
                rsp_data_q  <= result;
                rsp_id_q    <= gid;
                rsp_valid_q <= 1'b1;
            end
            if (release_op) begin
                rsp_valid_q <= 1'b0;
                ptr         <= (int'(gid) == NREQ - 1) ? '0 : gid + IDW'(1);
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state != IDLE);

endmodule

`default_nettype wire
